param_datapath: RTL and testbench

PARAM_DATAPATH -- requirements
Module: param_datapath

---
 rtl/datapath_pkg.sv | 27 ++
 rtl/bus_mux_n.sv | 18 +
 rtl/param_datapath.sv | 224 ++++++++++++++++++++++
 tb/tb_param_datapath.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the param_datapath slice: op codes, sequencer states and the default width.
package datapath_pkg;

    localparam int unsigned DataWDefault = 32;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpShl  = 4'd4,
        OpShr  = 4'd5,
        OpMul  = 4'd6,
        OpDiv  = 4'd7,
        OpMfhi = 4'd8,
        OpMflo = 4'd9,
        OpLdi  = 4'd10
    } op_e;

    typedef enum logic [2:0] {StIdle, StY, StExec, StIter, StWb} state_e;

    // Codes above OpLdi are unused; DIV counts as unused when the divider is not built.
    function automatic logic op_known(logic [3:0] op, logic div_en);
        return (op <= OpLdi) && (div_en || (op != OpDiv));
    endfunction

endpackage

// File: rtl/bus_mux_n.sv
// One-hot selected N:1 mux forming the datapath's internal bus; an empty select yields zero.
module bus_mux_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned DataW = 32
) (
    input  logic [N-1:0]            sel_i,
    input  logic [N-1:0][DataW-1:0] data_i,
    output logic [DataW-1:0]        data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            data_o = data_o | (data_i[i] & {DataW{sel_i[i]}});
        end
    end

endmodule

// File: rtl/param_datapath.sv
// Single-bus micro-sequenced datapath: register file, HI/LO, Y/Z latches, shift-add MUL and
// optional restoring DIV (built only when PARAM_DATAPATH_DIV_EN is defined).
module param_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W   = DataWDefault,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [SEL_W-1:0]  rs_sel,
    input  logic [SEL_W-1:0]  rt_sel,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic [DATA_W-1:0] imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err,
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned ShW    = $clog2(DATA_W);
    localparam int unsigned NumSrc = NUM_REGS + 3;
    localparam int unsigned SrcHi  = NUM_REGS;
    localparam int unsigned SrcLo  = NUM_REGS + 1;
    localparam int unsigned SrcImm = NUM_REGS + 2;

    state_e                           state_q, state_d;
    logic [3:0]                       op_q, op_d;
    logic [SEL_W-1:0]                 rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0]                imm_q, imm_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DATA_W-1:0]                hi_q, hi_d, lo_q, lo_d, y_q, y_d, result_q;
    logic [2*DATA_W-1:0]              z_q, z_d;
    logic [ShW-1:0]                   cnt_q, cnt_d;
    logic                             dz_q, dz_d;

    logic [NumSrc-1:0]                bus_sel;
    logic [NumSrc-1:0][DATA_W-1:0]    bus_src;
    logic [DATA_W-1:0]                bus, alu_out;
    logic [DATA_W:0]                  mul_sum;
    logic [2*DATA_W-1:0]              mul_step, div_step;
    logic                             is_mul, is_div, is_mf;

    assign bus_src = {imm_q, lo_q, hi_q, regs_q};

    bus_mux_n #(
        .N     (NumSrc),
        .DataW (DATA_W)
    ) u_bus_mux (
        .sel_i  (bus_sel),
        .data_i (bus_src),
        .data_o (bus)
    );

`ifdef PARAM_DATAPATH_DIV_EN
    localparam logic DivEn = 1'b1;
    logic [DATA_W:0] div_rem_sh, div_diff;
    // Restoring step on {remainder, dividend}: shift left, trial-subtract the divisor on the bus.
    assign div_rem_sh = {z_q[2*DATA_W-1:DATA_W], z_q[DATA_W-1]};
    assign div_diff   = div_rem_sh - {1'b0, bus};
    assign div_step   = div_diff[DATA_W] ? {div_rem_sh[DATA_W-1:0], z_q[DATA_W-2:0], 1'b0}
                                         : {div_diff[DATA_W-1:0], z_q[DATA_W-2:0], 1'b1};
`else
    localparam logic DivEn = 1'b0;
    assign div_step = '0;
`endif

    assign is_mul   = (op_q == OpMul);
    assign is_div   = DivEn && (op_q == OpDiv);
    assign is_mf    = (op_q == OpMfhi) || (op_q == OpMflo);
    assign op_ready = (state_q == StIdle);
    assign dbg_data = regs_q[dbg_sel];

    // Shift-add step on {product_hi, multiplier}: add multiplicand (bus) if LSB set, shift right.
    assign mul_sum  = {1'b0, z_q[2*DATA_W-1:DATA_W]} + (z_q[0] ? {1'b0, bus} : '0);
    assign mul_step = {mul_sum, z_q[DATA_W-1:1]};

    always_comb begin
        case (op_q)
            OpAdd:   alu_out = y_q + bus;
            OpSub:   alu_out = y_q - bus;
            OpAnd:   alu_out = y_q & bus;
            OpOr:    alu_out = y_q | bus;
            OpShl:   alu_out = y_q << bus[ShW-1:0];
            OpShr:   alu_out = y_q >> bus[ShW-1:0];
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        bus_sel = '0;
        unique case (state_q)
            StY: begin
                if (op_q == OpMfhi)      bus_sel[SrcHi] = 1'b1;
                else if (op_q == OpMflo) bus_sel[SrcLo] = 1'b1;
                else                     bus_sel[rs_q]  = 1'b1;
            end
            StExec, StIter: bus_sel[rt_q] = 1'b1;
            StWb:           bus_sel[SrcImm] = (op_q == OpLdi);
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        regs_d  = regs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        done    = 1'b0;
        err     = 1'b0;
        result  = result_q;
        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    op_d    = op_code;
                    rs_d    = rs_sel;
                    rt_d    = rt_sel;
                    rd_d    = rd_sel;
                    imm_d   = imm;
                    dz_d    = 1'b0;
                    state_d = (op_code == OpLdi || !op_known(op_code, DivEn)) ? StWb : StY;
                end
            end
            StY: begin
                y_d   = bus;
                z_d   = {{DATA_W{1'b0}}, bus};
                cnt_d = '0;
                // MUL re-reads Rt every iteration, so it needs no separate operand cycle.
                if (is_mf)       state_d = StWb;
                else if (is_mul) state_d = StIter;
                else             state_d = StExec;
            end
            StExec: begin
                z_d     = {{DATA_W{1'b0}}, alu_out};
                state_d = StWb;
                if (is_div) begin
                    if (bus == '0) begin
                        z_d  = {y_q, {DATA_W{1'b1}}};
                        dz_d = 1'b1;
                    end else begin
                        z_d     = {{DATA_W{1'b0}}, y_q};
                        state_d = StIter;
                    end
                end
            end
            StIter: begin
                z_d   = is_mul ? mul_step : div_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ShW'(DATA_W - 1)) state_d = StWb;
            end
            StWb: begin
                done    = 1'b1;
                state_d = StIdle;
                if (!op_known(op_q, DivEn)) begin
                    err = 1'b1;
                end else if (is_mul || is_div) begin
                    hi_d   = z_q[2*DATA_W-1:DATA_W];
                    lo_d   = z_q[DATA_W-1:0];
                    result = z_q[DATA_W-1:0];
                    err    = dz_q;
                end else if (op_q == OpLdi) begin
                    regs_d[rd_q] = bus;
                    result       = bus;
                end else if (is_mf) begin
                    regs_d[rd_q] = y_q;
                    result       = y_q;
                end else begin
                    regs_d[rd_q] = z_q[DATA_W-1:0];
                    result       = z_q[DATA_W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            regs_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            z_q      <= '0;
            cnt_q    <= '0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            regs_q   <= regs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            z_q      <= z_d;
            cnt_q    <= cnt_d;
            dz_q     <= dz_d;
            result_q <= result;
        end
    end

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboarded bench for param_datapath (DATA_W=32, NUM_REGS=16); DIV expectations follow
// PARAM_DATAPATH_DIV_EN.
module tb_param_datapath;
    import datapath_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          clr, op_valid, op_ready, done, err;
    logic [3:0]    op_code;
    logic [SW-1:0] rs_sel, rt_sel, rd_sel, dbg_sel;
    logic [DW-1:0] imm, result, dbg_data;
    int            tests = 0;
    int            fails = 0;

    typedef struct { logic [DW-1:0] res; logic err; int lat; bit chk_res; } exp_t;
    typedef struct { logic [DW-1:0] res; logic err; int lat; bit timeout; } obs_t;
    typedef struct { logic [3:0] op; int rd; int rs; int rt; logic [DW-1:0] im; } stim_t;

    exp_t          sb[$];
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_hi, m_lo;

    param_datapath #(
        .DATA_W   (DW),
        .NUM_REGS (NR)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .rs_sel   (rs_sel),
        .rt_sel   (rt_sel),
        .rd_sel   (rd_sel),
        .imm      (imm),
        .done     (done),
        .result   (result),
        .err      (err),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference model: updates architectural state and queues the expected completion.
    task automatic model_push(input logic [3:0] op, input int rd, input int rs, input int rt,
                              input logic [DW-1:0] im);
        exp_t          e;
        logic [63:0]   p;
        logic [DW-1:0] a, b;
        a = m_regs[rs];
        b = m_regs[rt];
        e.err = 1'b0;
        e.chk_res = 1'b1;
        e.res = '0;
        e.lat = 3;
        case (op)
            OpAdd: e.res = a + b;
            OpSub: e.res = a - b;
            OpAnd: e.res = a & b;
            OpOr:  e.res = a | b;
            OpShl: e.res = a << b[4:0];
            OpShr: e.res = a >> b[4:0];
            OpMul: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                e.res = m_lo;
                e.lat = 34;
            end
`ifdef PARAM_DATAPATH_DIV_EN
            OpDiv: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = '1;
                    e.err = 1'b1;
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                    e.lat = 35;
                end
                e.res = m_lo;
            end
`endif
            OpMfhi: begin e.res = m_hi; e.lat = 2; end
            OpMflo: begin e.res = m_lo; e.lat = 2; end
            OpLdi:  begin e.res = im;   e.lat = 1; end
            default: begin e.err = 1'b1; e.lat = 1; e.chk_res = 1'b0; end
        endcase
        if (!e.err && op != OpMul && op != OpDiv) m_regs[rd] = e.res;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input int rd, input int rs, input int rt,
                         input logic [DW-1:0] im);
        int n = 0;
        while (op_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        op_code  = op;
        rd_sel   = SW'(rd);
        rs_sel   = SW'(rs);
        rt_sel   = SW'(rt);
        imm      = im;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    // Drives one op and waits for done; returns at the sample point after the writeback edge.
    task automatic exec_op(input logic [3:0] op, input int rd, input int rs, input int rt,
                           input logic [DW-1:0] im, output obs_t o);
        model_push(op, rd, rs, rt, im);
        issue(op, rd, rs, rt, im);
        o.lat = 1;
        while (done !== 1'b1 && o.lat < 100) begin @(posedge clk); #1; o.lat++; end
        o.timeout = (done !== 1'b1);
        o.res = result;
        o.err = err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; op_valid = 1'b0; op_code = '0; imm = '0;
        rs_sel = '0; rt_sel = '0; rd_sel = '0; dbg_sel = '0;
        m_regs = '{default: '0}; m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", op_ready); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        tests++; if (result !== '0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
        for (int r = 0; r < NR; r++) begin
            dbg_sel = SW'(r);
            @(negedge clk);
            tests++;
            if (dbg_data !== '0) begin fails++; $display("FAIL reset_reg R%0d: got %h want 0", r, dbg_data); end
        end
    endtask

    task automatic test_alu();
        stim_t t [11];
        obs_t  o;
        exp_t  e;
        t = '{'{OpLdi, 1, 0, 0, 32'hFFFF_FFFF}, '{OpLdi, 2, 0, 0, 32'h1},
              '{OpAdd, 3, 1, 2, 32'h0},         '{OpSub, 4, 2, 1, 32'h0},
              '{OpLdi, 5, 0, 0, 32'hF0F0_1234}, '{OpAnd, 6, 5, 1, 32'h0},
              '{OpOr,  7, 5, 2, 32'h0},         '{OpLdi, 8, 0, 0, 32'd36},
              '{OpShl, 9, 5, 8, 32'h0},         '{OpShr, 10, 5, 8, 32'h0},
              '{OpAdd, 1, 1, 1, 32'h0}};
        for (int i = 0; i < 11; i++) begin
            exec_op(t[i].op, t[i].rd, t[i].rs, t[i].rt, t[i].im, o);
            e = sb.pop_front();
            tests++;
            if (o.timeout || o.lat !== e.lat) begin
                fails++; $display("FAIL alu_lat[%0d]: got %0d want %0d", i, o.lat, e.lat);
            end
            tests++;
            if (o.err !== e.err) begin fails++; $display("FAIL alu_err[%0d]: got %b want %b", i, o.err, e.err); end
            tests++;
            if (o.res !== e.res) begin fails++; $display("FAIL alu_res[%0d]: got %h want %h", i, o.res, e.res); end
        end
        for (int r = 0; r < NR; r++) begin
            dbg_sel = SW'(r);
            @(negedge clk);
            tests++;
            if (dbg_data !== m_regs[r]) begin
                fails++; $display("FAIL alu_reg R%0d: got %h want %h", r, dbg_data, m_regs[r]);
            end
            if (r == 3 || r == 4 || r == 9 || r == 1) begin
                tests++;
                if (dbg_data !== ((r == 3) ? 32'h0 : (r == 4) ? 32'h2 : (r == 9) ? 32'h0F01_2340
                                  : 32'hFFFF_FFFE)) begin
                    fails++; $display("FAIL alu_const R%0d: got %h", r, dbg_data);
                end
            end
        end
    endtask

    task automatic test_mul();
        stim_t t [13];
        obs_t  o;
        exp_t  e;
        t = '{'{OpLdi, 1, 0, 0, 32'h1_0000}, '{OpLdi, 2, 0, 0, 32'h1_0000},
              '{OpMul, 0, 1, 2, 32'h0},      '{OpMfhi, 4, 0, 0, 32'h0},
              '{OpMflo, 5, 0, 0, 32'h0},     '{OpLdi, 7, 0, 0, $urandom},
              '{OpLdi, 8, 0, 0, $urandom},   '{OpMul, 0, 7, 8, 32'h0},
              '{OpMfhi, 9, 0, 0, 32'h0},     '{OpMflo, 10, 0, 0, 32'h0},
              '{OpLdi, 8, 0, 0, 32'hFFFF_FFFF}, '{OpMul, 0, 8, 8, 32'h0},
              '{OpMfhi, 11, 0, 0, 32'h0}};
        for (int i = 0; i < 13; i++) begin
            exec_op(t[i].op, t[i].rd, t[i].rs, t[i].rt, t[i].im, o);
            e = sb.pop_front();
            tests++;
            if (o.timeout || o.lat !== e.lat) begin
                fails++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, o.lat, e.lat);
            end
            tests++;
            if (o.err !== e.err) begin fails++; $display("FAIL mul_err[%0d]: got %b want %b", i, o.err, e.err); end
            tests++;
            if (o.res !== e.res) begin fails++; $display("FAIL mul_res[%0d]: got %h want %h", i, o.res, e.res); end
        end
        dbg_sel = 4'd4;
        @(negedge clk);
        tests++; if (dbg_data !== 32'h1) begin fails++; $display("FAIL mul_hi_r4: got %h want 1", dbg_data); end
        dbg_sel = 4'd11;
        @(negedge clk);
        tests++;
        if (dbg_data !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mul_max_hi: got %h want fffffffe", dbg_data); end
    endtask

    task automatic test_div();
        stim_t         t [9];
        obs_t          o;
        exp_t          e;
        logic [DW-1:0] hi0, lo0;
        t = '{'{OpLdi, 1, 0, 0, 32'd100}, '{OpLdi, 2, 0, 0, 32'd7},
              '{OpDiv, 0, 1, 2, 32'h0},   '{OpMfhi, 11, 0, 0, 32'h0},
              '{OpMflo, 12, 0, 0, 32'h0}, '{OpLdi, 2, 0, 0, 32'd0},
              '{OpDiv, 0, 1, 2, 32'h0},   '{OpMfhi, 13, 0, 0, 32'h0},
              '{OpMflo, 14, 0, 0, 32'h0}};
        hi0 = m_hi;
        lo0 = m_lo;
        for (int i = 0; i < 9; i++) begin
            exec_op(t[i].op, t[i].rd, t[i].rs, t[i].rt, t[i].im, o);
            e = sb.pop_front();
            tests++;
            if (o.timeout || o.lat !== e.lat) begin
                fails++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, o.lat, e.lat);
            end
            tests++;
            if (o.err !== e.err) begin fails++; $display("FAIL div_err[%0d]: got %b want %b", i, o.err, e.err); end
            if (e.chk_res) begin
                tests++;
                if (o.res !== e.res) begin fails++; $display("FAIL div_res[%0d]: got %h want %h", i, o.res, e.res); end
            end
        end
        for (int r = 0; r < NR; r++) begin
            dbg_sel = SW'(r);
            @(negedge clk);
            tests++;
            if (dbg_data !== m_regs[r]) begin
                fails++; $display("FAIL div_reg R%0d: got %h want %h", r, dbg_data, m_regs[r]);
            end
        end
        for (int r = 11; r < 15; r++) begin
            dbg_sel = SW'(r);
            @(negedge clk);
            tests++;
`ifdef PARAM_DATAPATH_DIV_EN
            if (dbg_data !== ((r == 11) ? 32'd2 : (r == 12) ? 32'd14 : (r == 13) ? 32'd100
                              : 32'hFFFF_FFFF)) begin
`else
            if (dbg_data !== ((r % 2 == 1) ? hi0 : lo0)) begin
`endif
                fails++; $display("FAIL div_hilo R%0d: got %h", r, dbg_data);
            end
        end
    endtask

    task automatic test_bad_op();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            exec_op((i == 0) ? 4'd11 : (i == 1) ? 4'd12 : 4'd15, 5, 1, 2, 32'h5A5A_5A5A, o);
            e = sb.pop_front();
            tests++;
            if (o.timeout || o.lat !== e.lat) begin
                fails++; $display("FAIL bad_lat[%0d]: got %0d want %0d", i, o.lat, e.lat);
            end
            tests++;
            if (o.err !== 1'b1) begin fails++; $display("FAIL bad_err[%0d]: got %b want 1", i, o.err); end
        end
        for (int r = 0; r < NR; r++) begin
            dbg_sel = SW'(r);
            @(negedge clk);
            tests++;
            if (dbg_data !== m_regs[r]) begin
                fails++; $display("FAIL bad_reg R%0d: got %h want %h", r, dbg_data, m_regs[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int   seen = 0;
        obs_t o;
        exp_t e;
        issue(OpMul, 0, 1, 8, 32'h0);
        repeat (9) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        m_regs = '{default: '0}; m_hi = '0; m_lo = '0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL rmid_done: got %0d pulses want 0", seen); end
        tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b want 1", op_ready); end
        for (int r = 0; r < NR; r++) begin
            dbg_sel = SW'(r);
            @(negedge clk);
            tests++;
            if (dbg_data !== '0) begin fails++; $display("FAIL rmid_reg R%0d: got %h want 0", r, dbg_data); end
        end
        exec_op(OpMfhi, 3, 0, 0, 32'h0, o);
        e = sb.pop_front();
        tests++;
        if (o.timeout || o.res !== e.res) begin fails++; $display("FAIL rmid_hi: got %h want %h", o.res, e.res); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e1, e2;
        int   cyc, busy_bad;
        exec_op(OpLdi, 1, 0, 0, 32'h0001_2345, o);
        e1 = sb.pop_front();
        exec_op(OpLdi, 2, 0, 0, 32'h0000_0100, o);
        e2 = sb.pop_front();
        tests++;
        if (o.timeout || o.lat !== e2.lat) begin fails++; $display("FAIL b2b_ldi: got %0d want %0d", o.lat, e2.lat); end
        model_push(OpMul, 0, 1, 2, 32'h0);
        model_push(OpAdd, 4, 1, 2, 32'h0);
        e1 = sb.pop_front();
        e2 = sb.pop_front();
        issue(OpMul, 0, 1, 2, 32'h0);
        op_code = OpAdd; rd_sel = 4'd4; rs_sel = 4'd1; rt_sel = 4'd2; op_valid = 1'b1;
        cyc = 1;
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (op_ready !== 1'b0) busy_bad++;
            @(posedge clk); #1; cyc++;
        end
        if (op_ready !== 1'b0) busy_bad++;
        tests++; if (busy_bad != 0) begin fails++; $display("FAIL b2b_busy: got %0d ready cycles want 0", busy_bad); end
        tests++; if (cyc != e1.lat) begin fails++; $display("FAIL b2b_mul_lat: got %0d want %0d", cyc, e1.lat); end
        tests++; if (result !== e1.res) begin fails++; $display("FAIL b2b_mul_res: got %h want %h", result, e1.res); end
        @(posedge clk); #1;
        tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after: got %b want 1", op_ready); end
        @(posedge clk); #1;
        op_valid = 1'b0;
        tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL b2b_accept: got %b want 0", op_ready); end
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        tests++; if (cyc != e2.lat) begin fails++; $display("FAIL b2b_add_lat: got %0d want %0d", cyc, e2.lat); end
        tests++; if (result !== e2.res) begin fails++; $display("FAIL b2b_add_res: got %h want %h", result, e2.res); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_bad_op();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
